crypto_access_arbiter: RTL and testbench
========================================

// Module: crypto_access_arbiter
// PURPOSE
//  Shares the single AES-lite encryptor among NUM_REQ requesters (command path, telemetry, threat log, ...).
//  Requesters use a valid/ready handshake. Selection order: starvation override first, then priority mask, then round-robin.
//  The block sequences one encryption at a time and returns the ciphertext tagged with the requester ID.
//  It sits between the requesting subsystems and the encryptor, inside the ew_sim top level.
// PARAMETERS
//  NUM_REQ      4   number of requesters, 2..8
//  DATA_W       8   plaintext/ciphertext width
//  ENC_LAT      1   encryptor latency: cycles from enc_start to valid enc_data_out, >=1
//  STARVE_LIMIT 12  wait cycles after which a pending requester is forced to win, 1..15
// PORTS
//  clk           in   1                clock, all logic on rising edge
//  reset         in   1                synchronous, active-high
//  req_valid     in   NUM_REQ          per-requester request pending
//  req_data      in   NUM_REQ*DATA_W   plaintext; requester i at [i*DATA_W +: DATA_W]
//  high_prio     in   NUM_REQ          requesters that bypass round-robin
//  req_ready     out  NUM_REQ          one-hot grant; transfer when req_valid[i]&req_ready[i]
//  enc_start     out  1                one-cycle pulse launching encryption
//  enc_data_in   out  DATA_W           plaintext to encryptor, held stable from enc_start to capture
//  enc_data_out  in   DATA_W           ciphertext from encryptor
//  rsp_valid     out  1                response available
//  rsp_data      out  DATA_W           ciphertext
//  rsp_id        out  $clog2(NUM_REQ)  index of the originating requester
//  rsp_ready     in   1                consumer accepts response
//  busy          out  1                high in every state except IDLE
// BEHAVIOUR
//  Reset values: req_ready=0, enc_start=0, enc_data_in=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
//   Also cleared: rr_ptr=0, all wait counters=0, state=IDLE.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: req_ready is a combinational one-hot of the winner; it is all-zero if no req_valid is set.
//   Winner selection:
//    (1) lowest index i with req_valid[i] and wait_cnt[i]==STARVE_LIMIT;
//    (2) otherwise, lowest index in req_valid&high_prio;
//    (3) otherwise, first valid index scanning from rr_ptr upward, wrapping mod NUM_REQ.
//   On grant: latch req_data[winner] into enc_data_in, latch winner into rsp_id, clear wait_cnt[winner].
//    Set rr_ptr=(winner+1)%NUM_REQ for every grant, including priority and starvation grants. Next state is ISSUE.
//  ISSUE: enc_start=1 for exactly this cycle; load latency counter with ENC_LAT. Next state is WAIT.
//  WAIT: decrement the counter each cycle. When it reaches 0, capture enc_data_out into rsp_data. Next state is RESP.
//  RESP: rsp_valid=1, with rsp_data and rsp_id held. Return to IDLE in the cycle after rsp_valid&rsp_ready.
//   No new grant is made in RESP.
//  Latency (ENC_LAT=1): handshake at cycle T; enc_start at T+1; capture at T+2; rsp_valid from T+3.
//   Minimum spacing between grants is ENC_LAT+3 cycles.
//  Wait counters (4-bit): increment when req_valid[i] is set and requester i is not granted, in any state.
//   Saturate at STARVE_LIMIT. Cleared when req_valid[i] drops or on grant.
//  A requester that drops req_valid before it is granted is simply skipped; no error is raised.
//  req_data is sampled only on the handshake cycle; later changes have no effect.
//  Simultaneous starved and high_prio requesters: the starved requester wins.
//  Reset mid-operation: the in-flight job is abandoned. No rsp_valid is produced. All state returns to reset values on the next edge.
//  enc_data_in and rsp_id are not cleared after RESP; they hold the last values.
// CONFIGURATION
//  CRYPTO_ARB_STATS_EN defined:
//   adds output stall_cnt[15:0], which counts cycles with rsp_valid&!rsp_ready, saturating at 16'hFFFF.
//   adds output grant_cnt[NUM_REQ*8-1:0], per-requester 8-bit grant counters that wrap.
//   All counters reset to 0.
//  CRYPTO_ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Single request: req_valid=4'b0100, data 8'hA5, rsp_ready=1.
//    -> req_ready=4'b0100 at T; enc_start at T+1; rsp_valid at T+3 with rsp_id=2 and rsp_data=encryptor output.
//  2 Round-robin: req_valid=4'b1111 held, high_prio=0, rsp_ready=1 -> grant order 0,1,2,3,0.
//  3 Priority: req_valid=4'b1111, high_prio=4'b1000 held -> req3 wins until the starvation override fires.
//    Then req0 wins once its wait_cnt hits 12.
//  4 Backpressure: rsp_ready=0 for 10 cycles in RESP.
//    -> rsp_valid, rsp_data and rsp_id are stable, enc_start=0, req_ready=0. Grant resumes the cycle after the handshake.
//  5 Reset in WAIT: assert reset 1 cycle -> no rsp_valid; all outputs 0; next grant goes to lowest-index valid requester (rr_ptr=0).
//  6 STATS_EN: 3 grants to req1, 5 stall cycles -> grant_cnt[15:8]=3, stall_cnt=5.

Source files
------------

// File: rtl/crypto_access_arbiter.sv
// Shares one encryptor among NUM_REQ valid/ready requesters: starvation override, then priority, then round-robin.
// Optional CRYPTO_ARB_STATS_EN adds stall_cnt and per-requester grant_cnt outputs.
module crypto_access_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int ENC_LAT      = 1,
  parameter int STARVE_LIMIT = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         high_prio,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       enc_start,
  output logic [DATA_W-1:0]          enc_data_in,
  input  logic [DATA_W-1:0]          enc_data_out,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  input  logic                       rsp_ready,
  output logic                       busy
`ifdef CRYPTO_ARB_STATS_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [NUM_REQ*8-1:0]       grant_cnt
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int LAT_W = $clog2(ENC_LAT + 1);
  localparam logic [3:0] STARVE = 4'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [DATA_W-1:0] enc_data_in_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [3:0]        wait_q [NUM_REQ];

  logic            s_hit, p_hit, grant;
  logic [ID_W-1:0] s_idx, p_idx, r_idx, win;

  // Downward scans leave the lowest matching index (or nearest to rr_ptr) as the final assignment.
  always_comb begin
    s_hit = 1'b0;
    s_idx = '0;
    p_hit = 1'b0;
    p_idx = '0;
    r_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (wait_q[i] == STARVE)) begin
        s_hit = 1'b1;
        s_idx = ID_W'(i);
      end
      if (req_valid[i] && high_prio[i]) begin
        p_hit = 1'b1;
        p_idx = ID_W'(i);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        r_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    win = s_hit ? s_idx : (p_hit ? p_idx : r_idx);
  end

  assign grant = (state_q == S_IDLE) && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        lat_d   = LAT_W'(ENC_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lat_q         <= '0;
      rr_ptr_q      <= '0;
      enc_data_in_q <= '0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (grant) begin
        enc_data_in_q <= req_data[int'(win)*DATA_W +: DATA_W];
        rsp_id_q      <= win;
        rr_ptr_q      <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
      end
      // Final WAIT cycle: the encryptor output is valid now.
      if ((state_q == S_WAIT) && (lat_q == LAT_W'(1))) begin
        rsp_data_q <= enc_data_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset || !req_valid[i] || req_ready[i]) begin
        wait_q[i] <= 4'd0;
      end else if (wait_q[i] != STARVE) begin
        wait_q[i] <= wait_q[i] + 4'd1;
      end
    end
  end

  assign enc_start   = (state_q == S_ISSUE);
  assign rsp_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign enc_data_in = enc_data_in_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;

`ifdef CRYPTO_ARB_STATS_EN
  logic [15:0]          stall_cnt_q;
  logic [NUM_REQ*8-1:0] grant_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      if (rsp_valid && !rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          grant_cnt_q[i*8 +: 8] <= grant_cnt_q[i*8 +: 8] + 8'd1;
        end
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_crypto_access_arbiter.sv
// Directed vector table plus hand sequences for round-robin, priority/starvation and stats.
module tb_crypto_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  high_prio = '0;
  logic [3:0]  req_ready;
  logic        enc_start;
  logic [7:0]  enc_data_in;
  logic [7:0]  enc_data_out = 8'hEE;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready = 1'b1;
  logic        busy;
`ifdef CRYPTO_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [31:0] grant_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  crypto_access_arbiter #(.NUM_REQ(4), .DATA_W(8), .ENC_LAT(1), .STARVE_LIMIT(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .high_prio(high_prio),
    .req_ready(req_ready), .enc_start(enc_start), .enc_data_in(enc_data_in),
    .enc_data_out(enc_data_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
`ifdef CRYPTO_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cipher(input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h3C;
  endfunction

  // One-cycle encryptor: valid ciphertext only in the cycle after enc_start, junk otherwise.
  always @(posedge clk) enc_data_out <= enc_start ? cipher(enc_data_in) : 8'hEE;

  typedef struct {
    string       nm;
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  hp;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_st;
    logic [7:0]  e_din;
    logic        e_rv;
    logic [7:0]  e_rd;
    logic        ck_rd;
    logic [1:0]  e_id;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic rst, logic [3:0] vld, logic [31:0] dat, logic rr,
                              logic [3:0] e_rdy, logic e_st, logic [7:0] e_din, logic e_rv,
                              logic [7:0] e_rd, logic ck_rd, logic [1:0] e_id, logic e_busy);
    vec_t v;
    v.nm = nm; v.rst = rst; v.vld = vld; v.dat = dat; v.hp = 4'h0; v.rr = rr;
    v.e_rdy = e_rdy; v.e_st = e_st; v.e_din = e_din; v.e_rv = e_rv;
    v.e_rd = e_rd; v.ck_rd = ck_rd; v.e_id = e_id; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_data = '0; high_prio = '0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge after a grant; k = idle cycles scanned before it, idx = -1 on timeout.
  task automatic next_grant(output int idx, output int k);
    idx = -1;
    k = -1;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (req_ready != 4'b0) begin
        chk("grant_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        k = c;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int pr_exp[8] = '{3, 3, 3, 0, 1, 2, 3, 0};

  initial begin
    int idx, k;

    vecs.push_back(mk("reset_state", 0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h00, 0, 8'h00, 1, 2'd0, 0));
    vecs.push_back(mk("single_hs",   0, 4'b0100, 32'h00A50000, 1, 4'b0100, 0, 8'h00, 0, 8'h00, 1, 2'd0, 0));
    vecs.push_back(mk("single_iss",  0, 4'b0000, 32'h00FF0000, 1, 4'b0000, 1, 8'hA5, 0, 8'h00, 0, 2'd2, 1));
    vecs.push_back(mk("single_wait", 0, 4'b0000, 32'h00FF0000, 1, 4'b0000, 0, 8'hA5, 0, 8'h00, 0, 2'd2, 1));
    vecs.push_back(mk("single_resp", 0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'hA5, 1, 8'h66, 1, 2'd2, 1));
    vecs.push_back(mk("bp_hs",       0, 4'b0001, 32'h0000003C, 1, 4'b0001, 0, 8'hA5, 0, 8'h00, 0, 2'd2, 0));
    vecs.push_back(mk("bp_iss",      0, 4'b0001, 32'h000000FF, 1, 4'b0000, 1, 8'h3C, 0, 8'h00, 0, 2'd0, 1));
    vecs.push_back(mk("bp_wait",     0, 4'b0001, 32'h000000FF, 0, 4'b0000, 0, 8'h3C, 0, 8'h00, 0, 2'd0, 1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk($sformatf("bp_stall%0d", i), 0, 4'b0001, 32'h000000FF, 0,
                        4'b0000, 0, 8'h3C, 1, 8'hFF, 1, 2'd0, 1));
    vecs.push_back(mk("bp_ack",      0, 4'b0001, 32'h000000FF, 1, 4'b0000, 0, 8'h3C, 1, 8'hFF, 1, 2'd0, 1));
    vecs.push_back(mk("bp_regrant",  0, 4'b0001, 32'h000000FF, 1, 4'b0001, 0, 8'h3C, 0, 8'h00, 0, 2'd0, 0));
    vecs.push_back(mk("bp_iss2",     0, 4'b0000, 32'h0, 1, 4'b0000, 1, 8'hFF, 0, 8'h00, 0, 2'd0, 1));
    vecs.push_back(mk("bp_wait2",    0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'hFF, 0, 8'h00, 0, 2'd0, 1));
    vecs.push_back(mk("bp_resp2",    0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'hFF, 1, 8'hC3, 1, 2'd0, 1));
    vecs.push_back(mk("rst_hs",      0, 4'b0100, 32'h00770000, 1, 4'b0100, 0, 8'hFF, 0, 8'h00, 0, 2'd0, 0));
    vecs.push_back(mk("rst_iss",     0, 4'b0000, 32'h0, 1, 4'b0000, 1, 8'h77, 0, 8'h00, 0, 2'd2, 1));
    vecs.push_back(mk("rst_in_wait", 1, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h77, 0, 8'h00, 0, 2'd2, 1));
    vecs.push_back(mk("rst_after",   0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h00, 0, 8'h00, 1, 2'd0, 0));
    vecs.push_back(mk("rst_no_rsp",  0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h00, 0, 8'h00, 1, 2'd0, 0));
    vecs.push_back(mk("rst_rr0",     0, 4'b1111, 32'h44332211, 1, 4'b0001, 0, 8'h00, 0, 8'h00, 0, 2'd0, 0));
    vecs.push_back(mk("rst_iss2",    0, 4'b0000, 32'h0, 1, 4'b0000, 1, 8'h11, 0, 8'h00, 0, 2'd0, 1));
    vecs.push_back(mk("rst_wait2",   0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h11, 0, 8'h00, 0, 2'd0, 1));
    vecs.push_back(mk("rst_resp2",   0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h11, 1, 8'h2D, 1, 2'd0, 1));
    vecs.push_back(mk("rst_done",    0, 4'b0000, 32'h0, 1, 4'b0000, 0, 8'h11, 0, 8'h00, 0, 2'd0, 0));

    do_reset();
    foreach (vecs[n]) begin
      @(negedge clk);
      reset = vecs[n].rst; req_valid = vecs[n].vld; req_data = vecs[n].dat;
      high_prio = vecs[n].hp; rsp_ready = vecs[n].rr;
      #1;
      chk({vecs[n].nm, ".req_ready"}, 32'(req_ready), 32'(vecs[n].e_rdy));
      chk({vecs[n].nm, ".enc_start"}, 32'(enc_start), 32'(vecs[n].e_st));
      chk({vecs[n].nm, ".enc_data_in"}, 32'(enc_data_in), 32'(vecs[n].e_din));
      chk({vecs[n].nm, ".rsp_valid"}, 32'(rsp_valid), 32'(vecs[n].e_rv));
      if (vecs[n].ck_rd) chk({vecs[n].nm, ".rsp_data"}, 32'(rsp_data), 32'(vecs[n].e_rd));
      chk({vecs[n].nm, ".rsp_id"}, 32'(rsp_id), 32'(vecs[n].e_id));
      chk({vecs[n].nm, ".busy"}, 32'(busy), 32'(vecs[n].e_busy));
    end

    // Round-robin with all four requesting; grants spaced ENC_LAT+3 cycles.
    do_reset();
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      next_grant(idx, k);
      chk($sformatf("rr_grant%0d", g), 32'(idx), 32'(rr_exp[g]));
      if (g > 0) chk($sformatf("rr_spacing%0d", g), 32'(k), 32'd3);
    end

    // High priority on req3 until the starvation override hands out grants to the others.
    do_reset();
    req_valid = 4'hF;
    high_prio = 4'b1000;
    for (int g = 0; g < 8; g++) begin
      next_grant(idx, k);
      chk($sformatf("prio_grant%0d", g), 32'(idx), 32'(pr_exp[g]));
    end

`ifdef CRYPTO_ARB_STATS_EN
    do_reset();
    req_valid = 4'b0010;
    next_grant(idx, k);
    next_grant(idx, k);
    next_grant(idx, k);
    chk("stats_third_grant", 32'(idx), 32'd1);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid) begin
        idx = 1;
        break;
      end
      @(negedge clk);
    end
    chk("stats_rsp_seen", 32'(idx), 32'd1);
    repeat (5) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("stats_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("stats_grant_cnt", grant_cnt, 32'h0000_0300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
